// File: rtl/ro_meas_sched_pkg.sv
// Shared definitions for the ring-oscillator measurement scheduler:
// state encoding, width helpers and reset values.
package ro_meas_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_GATE,
    ST_SETTLE,
    ST_RESULT
  } state_t;

  localparam state_t RST_STATE = ST_IDLE;
  localparam logic   RST_FLAG  = 1'b0;

  function automatic int ch_width(input int num_osc);
    return (num_osc > 1) ? $clog2(num_osc) : 1;
  endfunction

  // One timer covers both the gate length and the settle/clear hold.
  function automatic int timer_width(input int gate_w, input int settle);
    int settle_w;
    settle_w = $clog2(settle) + 1;
    return (gate_w > settle_w) ? gate_w : settle_w;
  endfunction

endpackage

// File: rtl/ro_meas_sched_timer.sv
// Loadable down-counter; a load of V produces a done pulse V+1 cycles later,
// so the caller loads duration-1.
module meas_timer #(
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] value,
  output logic          done
);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      done  <= 1'b0;
    end else if (load) begin
      count <= value;
      done  <= (value == '0);
    end else if (count != '0) begin
      count <= count - 1'b1;
      done  <= (count == TW'(1));
    end else begin
      done  <= 1'b0;
    end
  end

endmodule

// File: rtl/ro_meas_sched.sv
// Sweeps the masked oscillator channels: clear, gate, settle, capture, and
// hands each count out over a valid/ready result port.
module ro_meas_sched
  import ro_meas_sched_pkg::*;
#(
  parameter int N       = 8,
  parameter int NUM_OSC = 4,
  parameter int GATE_W  = 16,
  parameter int SETTLE  = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           continuous,
  input  logic                           abort,
  input  logic [NUM_OSC-1:0]             chan_mask,
  input  logic [GATE_W-1:0]              gate_len,
  output logic [ch_width(NUM_OSC)-1:0]   osc_sel,
  output logic                           cnt_clr,
  output logic                           cnt_en,
  input  logic [N-1:0]                   cnt_value,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic [N-1:0]                   res_data,
  output logic [ch_width(NUM_OSC)-1:0]   res_chan,
  output logic                           res_ovf,
  output logic                           busy,
  output logic                           sweep_done
);

  localparam int CH_W = ch_width(NUM_OSC);
  localparam int TW   = timer_width(GATE_W, SETTLE);
  localparam logic [TW-1:0] SETTLE_LOAD = TW'(SETTLE - 1);

  typedef struct packed {
    logic            found;
    logic [CH_W-1:0] idx;
  } pick_t;

  state_t              state_q, state_d;
  logic [NUM_OSC-1:0]  mask_q;
  logic [CH_W-1:0]     chan_q, chan_d;
  logic [GATE_W-1:0]   gate_q;
  logic                load_mask, enter_clear, capture, sweep_d;
  logic                tmr_load, tmr_done;
  logic [TW-1:0]       tmr_value;
  pick_t               first_pick, next_pick;

  function automatic pick_t lowest_from(input logic [NUM_OSC-1:0] m, input int from);
    pick_t p;
    p = '0;
    for (int i = NUM_OSC - 1; i >= 0; i--) begin
      if (m[i] && (i >= from)) begin
        p.found = 1'b1;
        p.idx   = CH_W'(i);
      end
    end
    return p;
  endfunction

  assign first_pick = lowest_from(chan_mask, 0);
  assign next_pick  = lowest_from(mask_q, int'(chan_q) + 1);

  meas_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= RST_STATE;
      mask_q     <= '0;
      chan_q     <= '0;
      gate_q     <= '0;
      res_data   <= '0;
      res_chan   <= '0;
      res_ovf    <= RST_FLAG;
      sweep_done <= RST_FLAG;
    end else begin
      state_q    <= state_d;
      chan_q     <= chan_d;
      sweep_done <= sweep_d;
      if (load_mask)
        mask_q <= chan_mask;
      if (enter_clear)
        gate_q <= (gate_len == '0) ? '0 : gate_len - 1'b1;
      if (abort) begin
        res_data <= '0;
        res_chan <= '0;
        res_ovf  <= RST_FLAG;
      end else if (capture) begin
        res_data <= cnt_value;
        res_chan <= chan_q;
        res_ovf  <= &cnt_value;
      end
    end
  end

  // Every entry into CLEAR also samples gate_len and starts the clear hold.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    load_mask   = 1'b0;
    enter_clear = 1'b0;
    capture     = 1'b0;
    sweep_d     = 1'b0;
    tmr_load    = 1'b0;
    tmr_value   = SETTLE_LOAD;
    case (state_q)
      ST_IDLE: begin
        if (start && first_pick.found) begin
          state_d     = ST_CLEAR;
          load_mask   = 1'b1;
          chan_d      = first_pick.idx;
          enter_clear = 1'b1;
        end
      end
      ST_CLEAR: begin
        if (tmr_done) begin
          state_d   = ST_GATE;
          tmr_load  = 1'b1;
          tmr_value = TW'(gate_q);
        end
      end
      ST_GATE: begin
        if (tmr_done) begin
          state_d  = ST_SETTLE;
          tmr_load = 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_done) begin
          state_d = ST_RESULT;
          capture = 1'b1;
        end
      end
      ST_RESULT: begin
        if (res_ready) begin
          if (next_pick.found) begin
            state_d     = ST_CLEAR;
            chan_d      = next_pick.idx;
            enter_clear = 1'b1;
          end else begin
            sweep_d = 1'b1;
            if (continuous && first_pick.found) begin
              state_d     = ST_CLEAR;
              load_mask   = 1'b1;
              chan_d      = first_pick.idx;
              enter_clear = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (enter_clear)
      tmr_load = 1'b1;
    if (abort) begin
      state_d     = ST_IDLE;
      chan_d      = '0;
      load_mask   = 1'b0;
      enter_clear = 1'b0;
      capture     = 1'b0;
      sweep_d     = 1'b0;
      tmr_load    = 1'b0;
    end
  end

  always_comb begin
    cnt_clr   = (state_q == ST_CLEAR);
    cnt_en    = (state_q == ST_GATE);
    res_valid = (state_q == ST_RESULT);
    busy      = (state_q != ST_IDLE);
    osc_sel   = busy ? chan_q : '0;
  end

endmodule
